// File: rtl/character_engine.sv
// Dino-jump player character: per frame it erases the old sprite,
// steps the jump/move/duck physics and redraws from the sprite ROM.
module character_engine #(
  parameter int SPR_W     = 4,
  parameter int SPR_H     = 16,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = 160,
  parameter int GROUND_Y  = 51,
  parameter int X_INIT    = 10,
  parameter int X_STEP    = 1,
  parameter int JUMP_V    = 6,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 8,
  parameter int BG_COLOUR = 0,
  localparam int N        = SPR_W * SPR_H,
  localparam int AW       = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                jump,
  input  logic                duck,
  input  logic                left,
  input  logic                right,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [AW-1:0]       sprite_addr,
  input  logic [COLOUR_W-1:0] sprite_pixel,
  output logic [X_W-1:0]      x_pos,
  output logic [Y_W-1:0]      y_pos,
  output logic                ducking,
  output logic                airborne
);

  localparam int VW = Y_W + 2;

  localparam logic signed [VW-1:0] GND_S  = VW'(GROUND_Y);
  localparam logic signed [VW-1:0] TOFF_V = VW'(GRAVITY - JUMP_V);
  localparam logic signed [VW-1:0] GRV_S  = VW'(GRAVITY);
  localparam logic signed [VW-1:0] MAXF_S = VW'(MAX_FALL);
  localparam logic [AW-1:0]        K_LAST = AW'(N - 1);
  localparam logic [X_W:0]         XSTEP  = (X_W+1)'(X_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_UPDATE,
    S_DRAW,
    S_FLUSH
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         k_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  plot_q;
  logic                  rom_sel_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic [AW-1:0]         addr_q;

  logic [X_W-1:0]        xpos_q;
  logic [Y_W-1:0]        ypos_q;
  logic signed [VW-1:0]  vel_q;
  logic                  air_q;
  logic                  arm_q;
  logic                  duck_q;

  logic [X_W-1:0]        px_q;
  logic [Y_W-1:0]        py_q;
  logic                  pduck_q;

  logic [X_W-1:0]        xpos_d;
  logic [Y_W-1:0]        ypos_d;
  logic signed [VW-1:0]  vel_d;
  logic                  air_d;
  logic                  arm_d;
  logic                  duck_d;

  logic signed [VW-1:0]  ysum;
  logic signed [VW-1:0]  vsum;
  logic [X_W:0]          xw;
  logic [X_W:0]          xmax;

  // Footprint x of pixel k; a ducking sprite is rotated and bottom-aligned.
  function automatic logic [X_W-1:0] fp_x(
    input logic [AW-1:0]  k,
    input logic [X_W-1:0] xb,
    input logic           dk
  );
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = k / AW'(SPR_W);
    col = k % AW'(SPR_W);
    if (dk) begin
      fp_x = xb + X_W'(SPR_H - 1) - X_W'(row);
    end else begin
      fp_x = xb + X_W'(col);
    end
  endfunction

  // Footprint y of pixel k for the same two orientations.
  function automatic logic [Y_W-1:0] fp_y(
    input logic [AW-1:0]  k,
    input logic [Y_W-1:0] yb,
    input logic           dk
  );
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = k / AW'(SPR_W);
    col = k % AW'(SPR_W);
    if (dk) begin
      fp_y = yb + Y_W'(SPR_H - SPR_W) + Y_W'(col);
    end else begin
      fp_y = yb + Y_W'(row);
    end
  endfunction

  // Next-frame physics from the current state and the sampled keys.
  always_comb begin
    ypos_d = ypos_q;
    vel_d  = vel_q;
    air_d  = air_q;
    arm_d  = arm_q | ~jump;
    ysum   = $signed({2'b00, ypos_q}) + vel_q;
    vsum   = vel_q + GRV_S;
    if (!air_q && jump && arm_q) begin
      ypos_d = Y_W'(GROUND_Y - JUMP_V);
      vel_d  = TOFF_V;
      air_d  = 1'b1;
      arm_d  = 1'b0;
    end else if (air_q) begin
      if (ysum >= GND_S) begin
        ypos_d = Y_W'(GROUND_Y);
        vel_d  = '0;
        air_d  = 1'b0;
      end else if (ysum[VW-1]) begin
        ypos_d = '0;
        vel_d  = '0;
      end else begin
        ypos_d = ysum[Y_W-1:0];
        vel_d  = (vsum > MAXF_S) ? MAXF_S : vsum;
      end
    end

    duck_d = duck & ~jump & ~air_d;

    xmax = duck_d ? (X_W+1)'(SCREEN_W - SPR_H)
                  : (X_W+1)'(SCREEN_W - SPR_W);
    xw = {1'b0, xpos_q};
    if (left) begin
      xw = (xw >= XSTEP) ? xw - XSTEP : '0;
    end else if (right) begin
      xw = xw + XSTEP;
    end
    if (xw > xmax) begin
      xw = xmax;
    end
    xpos_d = xw[X_W-1:0];
  end

  // Frame sequencer: clear, update, draw, flush with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      plot_q    <= 1'b0;
      rom_sel_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      addr_q    <= '0;
      xpos_q    <= X_W'(X_INIT);
      ypos_q    <= Y_W'(GROUND_Y);
      vel_q     <= '0;
      air_q     <= 1'b0;
      arm_q     <= 1'b1;
      duck_q    <= 1'b0;
      px_q      <= X_W'(X_INIT);
      py_q      <= Y_W'(GROUND_Y);
      pduck_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            k_q       <= '0;
            plot_q    <= 1'b1;
            rom_sel_q <= 1'b0;
            colour_q  <= COLOUR_W'(BG_COLOUR);
            x_q       <= fp_x('0, px_q, pduck_q);
            y_q       <= fp_y('0, py_q, pduck_q);
          end
        end
        S_CLEAR: begin
          if (k_q == K_LAST) begin
            state_q <= S_UPDATE;
            plot_q  <= 1'b0;
          end else begin
            k_q <= k_q + AW'(1);
            x_q <= fp_x(k_q + AW'(1), px_q, pduck_q);
            y_q <= fp_y(k_q + AW'(1), py_q, pduck_q);
          end
        end
        S_UPDATE: begin
          xpos_q  <= xpos_d;
          ypos_q  <= ypos_d;
          vel_q   <= vel_d;
          air_q   <= air_d;
          arm_q   <= arm_d;
          duck_q  <= duck_d;
          px_q    <= xpos_d;
          py_q    <= ypos_d;
          pduck_q <= duck_d;
          state_q <= S_DRAW;
          k_q     <= '0;
          addr_q  <= '0;
        end
        S_DRAW: begin
          plot_q    <= 1'b1;
          rom_sel_q <= 1'b1;
          x_q       <= fp_x(k_q, xpos_q, duck_q);
          y_q       <= fp_y(k_q, ypos_q, duck_q);
          if (k_q == K_LAST) begin
            state_q <= S_FLUSH;
          end else begin
            k_q    <= k_q + AW'(1);
            addr_q <= k_q + AW'(1);
          end
        end
        S_FLUSH: begin
          state_q   <= S_IDLE;
          plot_q    <= 1'b0;
          rom_sel_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign plot        = plot_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = rom_sel_q ? sprite_pixel : colour_q;
  assign sprite_addr = addr_q;
  assign x_pos       = xpos_q;
  assign y_pos       = ypos_q;
  assign ducking     = duck_q;
  assign airborne    = air_q;

endmodule

// File: tb/tb_character_engine.sv
// Directed bench for character_engine: frame timing, plot streams,
// jump arc, duck footprint, x clamping, start masking and reset.
module tb_character_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       jump;
  logic       duck;
  logic       left;
  logic       right;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [5:0] sprite_addr;
  logic [2:0] sprite_pixel;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       ducking;
  logic       airborne;

  character_engine dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .jump         (jump),
    .duck         (duck),
    .left         (left),
    .right        (right),
    .busy         (busy),
    .done         (done),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .sprite_addr  (sprite_addr),
    .sprite_pixel (sprite_pixel),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .ducking      (ducking),
    .airborne     (airborne)
  );

  always #5 clock = ~clock;

  logic [2:0] rom [64];
  logic [2:0] rom_q;

  always @(posedge clock) rom_q <= rom[sprite_addr];
  assign sprite_pixel = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int pl_x [256];
  int pl_y [256];
  int pl_c [256];
  int pl_a [256];
  int np;
  int dcyc;
  int busy1;
  int busy_end;

  task automatic frame(input logic j, input logic d,
                       input logic l, input logic r);
    int pa;
    jump  = j;
    duck  = d;
    left  = l;
    right = r;
    np    = 0;
    dcyc  = 0;
    pa    = -1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    busy1 = busy;
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) begin
        @(posedge clock);
        #1;
      end
      if (plot) begin
        if (np < 256) begin
          pl_x[np] = x;
          pl_y[np] = y;
          pl_c[np] = colour;
          pl_a[np] = pa;
        end
        np++;
      end
      pa = sprite_addr;
      if (done) begin
        dcyc     = n;
        busy_end = busy;
        break;
      end
    end
    if (dcyc == 0) check("frame_timeout", 0, 1);
  endtask

  int yexp [14] = '{45, 40, 36, 33, 31, 30, 30,
                    31, 33, 36, 40, 45, 51, 51};

  initial begin
    int bad;
    int dones;
    int first;
    for (int i = 0; i < 64; i++) rom[i] = 3'((i * 3 + 1) % 8);
    reset = 1'b1;
    start = 1'b0;
    jump  = 1'b0;
    duck  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_xpos", x_pos, 10);
    check("rst_ypos", y_pos, 51);
    check("rst_duck", ducking, 0);
    check("rst_air", airborne, 0);
    check("rst_addr", sprite_addr, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);

    frame(0, 0, 0, 0);
    check("f1_done_cyc", dcyc, 131);
    check("f1_plots", np, 128);
    check("f1_busy1", busy1, 1);
    check("f1_busy_end", busy_end, 0);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (pl_x[k] != 10 + k % 4 || pl_y[k] != 51 + k / 4 || pl_c[k] != 0)
        bad++;
    check("f1_clear_px", bad, 0);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (pl_x[64+k] != 10 + k % 4 || pl_y[64+k] != 51 + k / 4) bad++;
    check("f1_draw_xy", bad, 0);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (pl_c[64+k] != int'(rom[k]) || pl_a[64+k] != k) bad++;
    check("f1_draw_rom", bad, 0);
    check("f1_xpos", x_pos, 10);
    check("f1_ypos", y_pos, 51);

    for (int f = 0; f < 14; f++) begin
      frame(1, 0, 0, 0);
      check("jump_y", y_pos, yexp[f]);
      check("jump_air", airborne, int'(f < 12));
    end
    frame(0, 0, 0, 0);
    check("rearm_y", y_pos, 51);
    frame(1, 0, 0, 0);
    check("rejump_y", y_pos, 45);
    check("rejump_air", airborne, 1);
    repeat (12) frame(0, 0, 0, 0);
    check("land_y", y_pos, 51);
    check("land_air", airborne, 0);

    frame(0, 1, 0, 0);
    check("duck_on", ducking, 1);
    check("duck_k0_x", pl_x[64], 25);
    check("duck_k0_y", pl_y[64], 63);
    check("duck_k63_x", pl_x[127], 10);
    check("duck_k63_y", pl_y[127], 66);
    frame(0, 0, 0, 0);
    check("duck_off", ducking, 0);
    check("unduck_clr0_x", pl_x[0], 25);
    check("unduck_clr0_y", pl_y[0], 63);
    check("unduck_clr63_x", pl_x[63], 10);
    check("unduck_clr63_y", pl_y[63], 66);
    check("unduck_draw0_x", pl_x[64], 10);

    repeat (145) frame(0, 0, 0, 1);
    check("right_155", x_pos, 155);
    frame(0, 0, 0, 1);
    check("right_156", x_pos, 156);
    frame(0, 0, 0, 1);
    check("right_sat", x_pos, 156);
    frame(0, 1, 0, 1);
    check("duck_clamp", x_pos, 144);
    check("duck_clamp_d", ducking, 1);
    frame(0, 0, 1, 1);
    check("left_prio", x_pos, 143);

    jump  = 1'b0;
    duck  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    dones = 0;
    first = 0;
    for (int n = 1; n <= 300; n++) begin
      if (n > 1) begin
        @(posedge clock);
        #1;
      end
      start = (n == 5 || n == 70);
      if (done) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    check("busy_start_dones", dones, 1);
    check("busy_start_cyc", first, 131);

    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int n = 2; n <= 85; n++) begin
      @(posedge clock);
      #1;
    end
    check("pre_rst_plot", plot, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_xpos", x_pos, 10);
    check("mid_rst_ypos", y_pos, 51);
    dones = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    check("mid_rst_nodone", dones, 0);
    frame(0, 0, 0, 0);
    check("post_rst_cyc", dcyc, 131);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
